// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin dti arbiter feeding one shared fifo2 write port
// Packet locking is compiled in when FIFO_ARB_PKT_LOCK_EN is defined.
module fifo_rr_arbiter #(
   parameter int  N   = 4,
   parameter int  DIN = 16,
   localparam int SW  = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*DIN-1:0] din_data,
   input  logic [N-1:0]     din_valid,
   output logic [N-1:0]     din_ready,
   output logic [DIN-1:0]   dout_data,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [SW-1:0]    dout_src,
   output logic             locked
);
   logic [SW-1:0]  last;
   logic [SW-1:0]  rr_gnt;
   logic           rr_valid;
   logic [SW-1:0]  cand;
   logic [SW-1:0]  gnt;
   logic           gnt_valid;
   logic           slot_free;
   logic           accept;
   logic [DIN-1:0] sel_data;

   assign slot_free = !dout_valid || dout_ready;

   // Scan from farthest to nearest so the requester right after 'last' wins.
   always_comb begin
      rr_gnt   = '0;
      rr_valid = 1'b0;
      cand     = '0;
      for (int k = N; k >= 1; k--) begin
         cand = SW'((int'(last) + k) % N);
         if (din_valid[cand]) begin
            rr_gnt   = cand;
            rr_valid = 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_PKT_LOCK_EN
   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
   lock_state_t   state, state_nxt;
   logic [SW-1:0] lock_idx, lock_idx_nxt;
   logic          sel_eot;

   assign locked    = (state == LOCKED);
   // While locked the grant is held even if the owner idles, blocking everyone else.
   assign gnt       = locked ? lock_idx : rr_gnt;
   assign gnt_valid = locked || rr_valid;
   assign sel_eot   = sel_data[DIN-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= UNLOCKED;
         lock_idx <= '0;
      end else begin
         state    <= state_nxt;
         lock_idx <= lock_idx_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      lock_idx_nxt = lock_idx;
      case (state)
         UNLOCKED: begin
            if (accept && !sel_eot) begin
               state_nxt    = LOCKED;
               lock_idx_nxt = gnt;
            end
         end
         LOCKED: begin
            if (accept && sel_eot) state_nxt = UNLOCKED;
         end
         default: state_nxt = UNLOCKED;
      endcase
   end
`else
   assign locked    = 1'b0;
   assign gnt       = rr_gnt;
   assign gnt_valid = rr_valid;
`endif

   assign sel_data  = din_data[gnt*DIN +: DIN];
   assign accept    = rst && gnt_valid && slot_free && din_valid[gnt];
   assign din_ready = (rst && gnt_valid && slot_free) ? (N'(1) << gnt) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_src   <= '0;
         last       <= SW'(N - 1);
      end else if (accept) begin
         dout_valid <= 1'b1;
         dout_data  <= sel_data;
         dout_src   <= gnt;
         last       <= gnt;
      end else if (dout_ready) begin
         dout_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed and randomized bench for fifo_rr_arbiter
// Producers are per-requester beat queues; expectations come from a behavioural arbitration model.
module tb_fifo_rr_arbiter;
   localparam int N   = 4;
   localparam int DIN = 16;
   localparam int SW  = 2;
   localparam int QD  = 64;
`ifdef FIFO_ARB_PKT_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N*DIN-1:0] din_data = '0;
   logic [N-1:0]     din_valid = '0;
   logic [N-1:0]     din_ready;
   logic [DIN-1:0]   dout_data;
   logic             dout_valid;
   logic             dout_ready = 1'b0;
   logic [SW-1:0]    dout_src;
   logic             locked;

   always #5 clk = ~clk;

   fifo_rr_arbiter #(.N(N), .DIN(DIN)) dut (
      .clk        (clk),
      .rst        (rst),
      .din_data   (din_data),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout_data  (dout_data),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_src   (dout_src),
      .locked     (locked)
   );

   logic [DIN-1:0] qmem [N][QD];
   int             qhead [N];
   int             qcnt  [N];
   bit             mute  [N];

   int             m_last;
   bit             m_locked;
   int             m_lock_idx;
   bit             m_dv;
   logic [DIN-1:0] m_data;
   int             m_src;

   int             obs[$];
   int             lk[$];
   int             nasrt = 0;
   int             nfail = 0;
   int             budget;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nasrt++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [DIN-1:0] beat);
      if (qcnt[i] < QD) begin
         qmem[i][(qhead[i] + qcnt[i]) % QD] = beat;
         qcnt[i]++;
      end
   endtask

   task automatic push_pkt(input int i, input int len, input int tag);
      for (int b = 0; b < len; b++)
         push(i, {(b == len - 1), 15'((tag << 4) + b)});
   endtask

   task automatic clear_queues();
      for (int i = 0; i < N; i++) begin
         qhead[i] = 0;
         qcnt[i]  = 0;
         mute[i]  = 0;
      end
   endtask

   task automatic model_reset();
      m_last = N - 1; m_locked = 0; m_lock_idx = 0;
      m_dv = 0; m_data = '0; m_src = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         din_valid[i] = (qcnt[i] > 0) && !mute[i];
         din_data[i*DIN +: DIN] = (qcnt[i] > 0) ? qmem[i][qhead[i]] : '0;
      end
   endtask

   function automatic bit pending();
      bit p = m_dv;
      for (int i = 0; i < N; i++) if (qcnt[i] > 0) p = 1;
      return p;
   endfunction

   // One clock: predict the grant from the rotation/lock rules, then check both sides of the edge.
   task automatic step();
      int g;
      bit slot, acc;
      logic [N-1:0] one, exp_rdy;
      one = 1;
      drive();
      #1;
      g = -1;
      if (LOCK_EN && m_locked) g = m_lock_idx;
      else for (int k = N; k >= 1; k--) if (din_valid[(m_last + k) % N]) g = (m_last + k) % N;
      slot    = !m_dv || dout_ready;
      exp_rdy = (slot && g >= 0) ? (one << g) : '0;
      acc     = 0;
      if (slot && g >= 0) acc = din_valid[g];
      check("din_ready", din_ready, exp_rdy);
      @(posedge clk);
      #1;
      if (acc) begin
         m_data = qmem[g][qhead[g]];
         m_dv = 1; m_src = g; m_last = g;
         if (LOCK_EN) begin
            if (!m_locked && !m_data[DIN-1]) begin
               m_locked = 1; m_lock_idx = g;
            end else if (m_locked && m_data[DIN-1]) begin
               m_locked = 0;
            end
         end
         qhead[g] = (qhead[g] + 1) % QD;
         qcnt[g]--;
      end else if (dout_ready) begin
         m_dv = 0;
      end
      check("dout_valid", dout_valid, m_dv);
      check("dout_data", dout_data, m_data);
      check("dout_src", dout_src, m_src);
      check("locked", locked, m_locked);
      if (dout_valid) obs.push_back(int'(dout_src));
      lk.push_back(int'(locked));
      @(negedge clk);
   endtask

   task automatic hw_reset();
      @(negedge clk);
      rst = 0;
      clear_queues();
      model_reset();
      drive();
      @(negedge clk);
      rst = 1;
      obs.delete();
      lk.delete();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < N; i++) mute[i] = 0;
      dout_ready = 1;
      budget = 0;
      while (pending() && budget < 300) begin
         step();
         budget++;
      end
      check(tag, pending(), 0);
   endtask

   initial begin
      clear_queues();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout_src", dout_src, 0);
      check("rst_dout_data", dout_data, 0);
      check("rst_locked", locked, 0);
      check("rst_din_ready_idle", din_ready, 0);
      for (int i = 0; i < N; i++) push(i, {1'b1, 15'(i * 16 + 1)});
      push(0, {1'b1, 15'h0055});
      drive();
      #1;
      check("rst_din_ready_req", din_ready, 0);

      // Single-beat packets from everyone rotate 0,1,2,3,0
      @(negedge clk);
      rst = 1;
      dout_ready = 1;
      obs.delete();
      repeat (5) step();
      check("rot_count", obs.size(), 5);
      check("rot0", obs[0], 0);
      check("rot1", obs[1], 1);
      check("rot2", obs[2], 2);
      check("rot3", obs[3], 3);
      check("rot4", obs[4], 0);
      drain("rot_drain");

      // 3-beat packet from req1 against a continuously valid req2
      hw_reset();
      dout_ready = 1;
      push_pkt(1, 3, 1);
      for (int b = 0; b < 4; b++) push(2, {1'b1, 15'(16'h0200 + b)});
      repeat (5) step();
      check("pkt_src0", obs[0], 1);
      check("pkt_src1", obs[1], LOCK_EN ? 1 : 2);
      check("pkt_src2", obs[2], 1);
      check("pkt_src3", obs[3], 2);
      check("pkt_src4", obs[4], LOCK_EN ? 2 : 1);
      check("pkt_lock_beat1", lk[0], LOCK_EN);
      check("pkt_lock_beat3", lk[2], 0);
      drain("pkt_drain");

      // Owner idles mid-packet; req3 must stay blocked only with locking
      hw_reset();
      dout_ready = 1;
      push_pkt(0, 3, 2);
      for (int b = 0; b < 3; b++) push(3, {1'b1, 15'(16'h0300 + b)});
      step();
      mute[0] = 1;
      repeat (2) begin
         drive();
         #1;
         check("gap_ready3", din_ready[3], !LOCK_EN);
         step();
      end
      mute[0] = 0;
      drain("gap_drain");
      check("gap_second_src", obs[1], LOCK_EN ? 0 : 3);

      // Backpressure holds 0xA5A5 stable
      hw_reset();
      dout_ready = 1;
      push(0, 16'hA5A5);
      push(1, 16'h8123);
      step();
      dout_ready = 0;
      repeat (5) begin
         step();
         check("stall_data", dout_data, 16'hA5A5);
         check("stall_ready", din_ready, 0);
      end
      dout_ready = 1;
      step();
      check("release_data", dout_data, 16'h8123);
      check("release_src", dout_src, 1);
      step();
      check("release_idle", dout_valid, 0);

      // Reset mid-packet abandons the packet and restores priority to req0
      hw_reset();
      dout_ready = 1;
      push_pkt(2, 3, 3);
      step();
      rst = 0;
      drive();
      #1;
      check("midrst_ready", din_ready, 0);
      check("midrst_valid", dout_valid, 0);
      check("midrst_locked", locked, 0);
      check("midrst_src", dout_src, 0);
      clear_queues();
      model_reset();
      push(3, 16'h8301);
      push(0, 16'h8001);
      push(1, 16'h8101);
      @(negedge clk);
      rst = 1;
      obs.delete();
      step();
      check("midrst_first", obs[0], 0);
      drain("midrst_drain");

      // Random traffic, backpressure and producer gaps
      hw_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            int r;
            r = $urandom_range(0, N - 1);
            if (qcnt[r] < QD - 4) push_pkt(r, $urandom_range(1, 4), c & 16'h07FF);
         end
         dout_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) mute[i] = ($urandom_range(0, 7) == 0);
         step();
      end
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end
endmodule
